// File: rtl/dut_soc_pkg.sv
// dut_soc_pkg
//   Shared definitions for the dut_soc system: data width, register count,
//   opcode encoding, instruction field positions, the CPU run/halt state type
//   and the immediate sign-extension helper.
`timescale 1ns/1ps
package dut_soc_pkg;

    localparam int XLEN  = 16;
    localparam int NREGS = 8;

    // Instruction field positions (LSB of each field)
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM6_W  = 6;
    localparam int IMM9_W  = 9;
    localparam int IMM12_W = 12;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_XOR  = 4'h3,
        OP_ADDI = 4'h4,
        OP_LBI  = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BRZ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cpu_state_e;

    // Sign-extend the low 'width' bits of raw to XLEN bits.
    function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] raw,
                                             input int unsigned   width);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] sign;
        mask = (XLEN'(1) << width) - XLEN'(1);
        sign = XLEN'(1) << (width - 1);
        return ((raw & mask) ^ sign) - sign;
    endfunction

endpackage

// File: rtl/dut_soc_cpu.sv
// soc_cpu
//   Single-cycle 16-bit CPU: program counter, 8-entry register file (r0 hard
//   zero), decode/execute and the sticky halt flop.
//   Ports:
//     clk, rst          clock and asynchronous active-high reset
//     imem_addr/data    instruction fetch port (combinational read)
//     dmem_addr         data address for both LD and ST
//     dmem_rdata        combinational data read
//     dmem_we/wdata     data write, taken by the memory at posedge clk
//     halt              high once HLT has executed, until reset
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_RUN  | executing one instruction per clock
//   ST_HALT | HLT seen; PC, registers and memory frozen
`timescale 1ns/1ps
module soc_cpu
    import dut_soc_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               halt
);

    cpu_state_e         state, state_next;
    logic [IMEM_AW-1:0] pc, pc_next;
    logic [XLEN-1:0]    regs [NREGS];

    logic [XLEN-1:0]    instr;
    opcode_e            op;
    logic [2:0]         rd, rs1, rs2;
    logic [XLEN-1:0]    rd_val, rs1_val, rs2_val;
    logic [XLEN-1:0]    imm6, imm9, imm12;
    logic [XLEN-1:0]    mem_ea;
    logic               rf_we;
    logic [XLEN-1:0]    rf_wdata;

    assign imem_addr = pc;
    assign instr     = imem_data;
    assign halt      = (state == ST_HALT);

    assign rd  = instr[RD_LSB  +: 3];
    assign rs1 = instr[RS1_LSB +: 3];
    assign rs2 = instr[RS2_LSB +: 3];

    assign rd_val  = (rd  == 3'd0) ? '0 : regs[rd];
    assign rs1_val = (rs1 == 3'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 3'd0) ? '0 : regs[rs2];

    assign imm6  = sext(XLEN'(instr[IMM6_W-1:0]),  IMM6_W);
    assign imm9  = sext(XLEN'(instr[IMM9_W-1:0]),  IMM9_W);
    assign imm12 = sext(XLEN'(instr[IMM12_W-1:0]), IMM12_W);

    // Full 16-bit address; the memory port keeps only the low bits so
    // out-of-range addresses alias modulo the depth.
    assign mem_ea     = rs1_val + imm6;
    assign dmem_addr  = DMEM_AW'(mem_ea);
    assign dmem_wdata = rd_val;

    always_comb begin
        op         = opcode_e'(instr[OP_LSB +: 4]);
        state_next = state;
        pc_next    = pc;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        dmem_we    = 1'b0;
        if (state == ST_RUN) begin
            pc_next = pc + IMEM_AW'(1);
            case (op)
                OP_ADD:  begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
                OP_SUB:  begin rf_we = 1'b1; rf_wdata = rs1_val - rs2_val; end
                OP_AND:  begin rf_we = 1'b1; rf_wdata = rs1_val & rs2_val; end
                OP_XOR:  begin rf_we = 1'b1; rf_wdata = rs1_val ^ rs2_val; end
                OP_ADDI: begin rf_we = 1'b1; rf_wdata = rs1_val + imm6;    end
                OP_LBI:  begin rf_we = 1'b1; rf_wdata = imm9;              end
                OP_LD:   begin rf_we = 1'b1; rf_wdata = dmem_rdata;        end
                // The memory has no reset of its own, so block writes while
                // reset is held even though the clock keeps running.
                OP_ST:   dmem_we = ~rst;
                OP_BRZ:  if (rd_val == '0)
                             pc_next = IMEM_AW'(XLEN'(pc) + XLEN'(1) + imm9);
                OP_JMP:  pc_next = IMEM_AW'(XLEN'(pc) + XLEN'(1) + imm12);
                OP_HLT:  begin pc_next = pc; state_next = ST_HALT; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (rf_we && (rd != 3'd0)) regs[rd] <= rf_wdata;
        end
    end

endmodule

// File: rtl/dut_soc.sv
// dut_soc
//   Self-contained simulation SoC: free-running clock generator, instruction
//   ROM, data RAM and the soc_cpu core.
//   Ports:
//     clk        generated clock, low at time 0, toggles every CLK_HALF
//                while pwrOn is high, holds its level otherwise
//     rst        asynchronous active-high reset
//     pwrOn      power enable; low acts as reset
//     firstWord  combinational view of data word 0
//     halt       sticky high after HLT executes
`timescale 1ns/1ps
module dut_soc
    import dut_soc_pkg::*;
#(
    parameter string IMEM_FILE  = "program.hex",
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter int    CLK_HALF   = 5
) (
    output logic            clk,
    input  logic            rst,
    input  logic            pwrOn,
    output logic [XLEN-1:0] firstWord,
    output logic            halt
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    logic [XLEN-1:0]    imem [IMEM_DEPTH];
    logic [XLEN-1:0]    dmem [DMEM_DEPTH];

    logic               rst_int;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DMEM_AW-1:0] dmem_addr;
    logic               dmem_we;
    logic [XLEN-1:0]    dmem_wdata;

    assign rst_int   = rst | ~pwrOn;
    assign firstWord = dmem[0];

    // Behavioural clock source: this block only exists in simulation.
    initial begin
        clk = 1'b0;
        forever begin
            #(CLK_HALF);
            if (pwrOn) clk = ~clk;
        end
    end

    // ROM and RAM power-up contents; the ROM image is filled in by the
    // harness.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
        for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    soc_cpu #(
        .IMEM_AW (IMEM_AW),
        .DMEM_AW (DMEM_AW)
    ) u_cpu (
        .clk        (clk),
        .rst        (rst_int),
        .imem_addr  (imem_addr),
        .imem_data  (imem[imem_addr]),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem[dmem_addr]),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .halt       (halt)
    );

endmodule

// File: tb/tb_dut_soc.sv
`timescale 1ns/1ps
module tb_dut_soc;

    logic        clk;
    logic        rst;
    logic        pwrOn;
    logic [15:0] firstWord;
    logic        halt;

    dut_soc #(.IMEM_FILE("")) dut (
        .clk       (clk),
        .rst       (rst),
        .pwrOn     (pwrOn),
        .firstWord (firstWord),
        .halt      (halt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int m_steps;

    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    logic [15:0] prog [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] enc_r(int op, int rd, int rs1, int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction
    function automatic logic [15:0] enc_i(int op, int rd, int rs1, int imm);
        return {4'(op), 3'(rd), 3'(rs1), 6'(imm)};
    endfunction
    function automatic logic [15:0] enc_b(int op, int rd, int imm);
        return {4'(op), 3'(rd), 9'(imm)};
    endfunction
    function automatic logic [15:0] enc_j(int imm);
        return {4'h9, 12'(imm)};
    endfunction
    localparam logic [15:0] HLT = 16'hF000;

    // Instruction-set interpreter over the bench's own copy of memory.
    // Executes up to max_steps instructions; steps = count executed
    // (the HLT itself included when it is reached).
    task automatic model_run(input int max_steps, output int steps);
        int pc, op, rd, rs1, rs2, i6, i9, i12, addr, nxt, v;
        int rr [8];
        bit wr;
        logic [15:0] w;
        pc = 0;
        for (int k = 0; k < 8; k++) rr[k] = 0;
        steps = max_steps;
        for (int s = 1; s <= max_steps; s++) begin
            w   = m_imem[pc];
            op  = int'(w[15:12]);
            rd  = int'(w[11:9]);
            rs1 = int'(w[8:6]);
            rs2 = int'(w[5:3]);
            i6  = int'(w[5:0]);  if (i6 > 31)    i6  -= 64;
            i9  = int'(w[8:0]);  if (i9 > 255)   i9  -= 512;
            i12 = int'(w[11:0]); if (i12 > 2047) i12 -= 4096;
            addr = (rr[rs1] + i6) & 255;
            nxt = pc + 1;
            wr  = 0;
            v   = 0;
            case (op)
                0:  begin wr = 1; v = rr[rs1] + rr[rs2]; end
                1:  begin wr = 1; v = rr[rs1] - rr[rs2]; end
                2:  begin wr = 1; v = rr[rs1] & rr[rs2]; end
                3:  begin wr = 1; v = rr[rs1] ^ rr[rs2]; end
                4:  begin wr = 1; v = rr[rs1] + i6; end
                5:  begin wr = 1; v = i9; end
                6:  begin wr = 1; v = int'(m_dmem[addr]); end
                7:  m_dmem[addr] = 16'(rr[rd]);
                8:  if (rr[rd] == 0) nxt = pc + 1 + i9;
                9:  nxt = pc + 1 + i12;
                15: begin steps = s; return; end
                default: ;
            endcase
            if (wr && rd != 0) rr[rd] = v & 32'hFFFF;
            pc = ((nxt % 256) + 256) % 256;
        end
    endtask

    task automatic load_prog(input logic [15:0] p [$]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 256; i++) begin
            m_imem[i]    = (i < p.size()) ? p[i] : HLT;
            dut.imem[i]  = m_imem[i];
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic step_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_to_halt();
        while (!halt && cyc < 10000) step_edges(1);
    endtask

    initial begin
        logic     lvl;
        time      t0;
        int       bad;
        int       r;
        int       op;
        logic [15:0] w;

        pwrOn = 1'b1;
        rst   = 1'b1;
        #1;
        check("clk_low_t0", clk, 1'b0);
        @(posedge clk); t0 = $time;
        @(posedge clk);
        check("clk_period", int'($time - t0), 10);
        #1;
        check("rst_halt", halt, 1'b0);
        check("rst_pc", dut.u_cpu.pc, 0);
        check("rst_firstword", firstWord, 16'h0000);

        // Immediate and store
        prog = {enc_b(5, 1, 7), enc_i(4, 1, 1, 5), enc_i(7, 1, 0, 0), HLT};
        load_prog(prog);
        model_run(10000, m_steps);
        release_rst();
        #1;
        check("imm_pc_after_release", dut.u_cpu.pc, 0);
        step_edges(3);
        check("imm_no_early_halt", halt, 1'b0);
        run_to_halt();
        check("imm_halt_edge", cyc, 4);
        check("imm_halt_edge_model", cyc, m_steps);
        check("imm_firstword", firstWord, 16'd12);
        check("imm_firstword_model", firstWord, m_dmem[0]);
        for (int i = 0; i < 6; i++) begin
            step_edges(1);
            check("imm_hold_halt", halt, 1'b1);
            check("imm_hold_word", firstWord, 16'd12);
        end

        // Power off acts as reset and freezes the clock
        pwrOn = 1'b0;
        #1;
        check("pwroff_halt", halt, 1'b0);
        check("pwroff_pc", dut.u_cpu.pc, 0);
        lvl = clk;
        #37;
        check("pwroff_clk_hold", clk, lvl);
        check("pwroff_dmem_kept", firstWord, 16'd12);
        pwrOn = 1'b1;

        // Loop and branch
        prog = {enc_b(5, 1, 3), enc_b(5, 2, 0),
                enc_i(4, 2, 2, 2), enc_i(4, 1, 1, -1),
                enc_b(8, 1, 1), enc_j(-4),
                enc_i(7, 2, 0, 0), HLT};
        load_prog(prog);
        model_run(10000, m_steps);
        release_rst();
        run_to_halt();
        check("loop_halted", halt, 1'b1);
        check("loop_cycles", cyc, m_steps);
        check("loop_firstword", firstWord, 16'd6);

        // Load, ALU
        prog = {enc_b(5, 1, 255), enc_i(7, 1, 0, 1),
                enc_b(5, 2, 240), enc_r(0, 2, 2, 2), enc_r(0, 2, 2, 2),
                enc_r(0, 2, 2, 2), enc_r(0, 2, 2, 2), enc_i(4, 2, 2, 15),
                enc_i(7, 2, 0, 2),
                enc_i(6, 3, 0, 1), enc_i(6, 4, 0, 2),
                enc_r(2, 5, 3, 4), enc_r(3, 6, 3, 4),
                enc_i(7, 5, 0, 3), enc_i(7, 6, 0, 0), HLT};
        load_prog(prog);
        model_run(10000, m_steps);
        release_rst();
        run_to_halt();
        check("alu_cycles", cyc, m_steps);
        check("alu_xor", firstWord, 16'h0FF0);
        check("alu_and", dut.dmem[3], 16'h000F);
        check("alu_and_model", dut.dmem[3], m_dmem[3]);

        // Address wrap: 256 aliases to 0
        prog = {enc_b(5, 3, 128), enc_r(0, 3, 3, 3), enc_b(5, 4, 16'h55),
                enc_i(7, 4, 3, 0), HLT};
        load_prog(prog);
        model_run(10000, m_steps);
        release_rst();
        step_edges(3);
        check("wrap_before_st", firstWord, 16'h0FF0);
        step_edges(1);
        check("wrap_after_st_edge", firstWord, 16'h0055);
        check("wrap_not_halted", halt, 1'b0);
        step_edges(1);
        check("wrap_halt", halt, 1'b1);
        check("wrap_model", firstWord, m_dmem[0]);

        // Halt stability and r0
        prog = {enc_b(5, 1, 5), enc_i(4, 0, 0, 9), enc_i(7, 0, 0, 0), HLT,
                enc_i(7, 1, 0, 0), enc_i(7, 1, 0, 1)};
        load_prog(prog);
        model_run(10000, m_steps);
        release_rst();
        run_to_halt();
        check("r0_cycles", cyc, m_steps);
        check("r0_firstword", firstWord, 16'h0000);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step_edges(1);
            if (halt !== 1'b1 || firstWord !== 16'h0000) bad++;
        end
        check("halt_stable_cycles", bad, 0);
        check("post_hlt_no_store", dut.dmem[1], m_dmem[1]);

        // Reset mid-run on the loop program
        prog = {enc_b(5, 1, 3), enc_b(5, 2, 0),
                enc_i(4, 2, 2, 2), enc_i(4, 1, 1, -1),
                enc_b(8, 1, 1), enc_j(-4),
                enc_i(7, 2, 0, 0), HLT};
        load_prog(prog);
        model_run(5, m_steps);
        model_run(10000, m_steps);
        release_rst();
        step_edges(5);
        #2 rst = 1'b1;
        #1;
        check("midrst_pc", dut.u_cpu.pc, 0);
        check("midrst_halt", halt, 1'b0);
        release_rst();
        run_to_halt();
        check("midrst_cycles", cyc, m_steps);
        check("midrst_firstword", firstWord, 16'd6);
        #2 rst = 1'b1;
        #1;
        check("rst_after_halt", halt, 1'b0);

        // Random straight-line programs with forward-only control flow
        for (int t = 0; t < 4; t++) begin
            prog = {};
            for (int i = 0; i < 24; i++) begin
                op = int'($urandom_range(0, 14));
                r  = int'($urandom);
                case (op)
                    0, 1, 2, 3: w = enc_r(op, r & 7, (r >> 3) & 7, (r >> 6) & 7);
                    4, 6, 7:    w = enc_i(op, r & 7, (r >> 3) & 7, r >> 6);
                    5:          w = enc_b(5, r & 7, r >> 3);
                    8:          w = enc_b(8, r & 7, (r >> 3) & 3);
                    9:          w = enc_j((r >> 3) & 3);
                    default:    w = {4'(op), 12'(r)};
                endcase
                prog.push_back(w);
            end
            prog.push_back(HLT);
            load_prog(prog);
            model_run(10000, m_steps);
            release_rst();
            run_to_halt();
            check("rand_cycles", cyc, m_steps);
            check("rand_firstword", firstWord, m_dmem[0]);
            bad = 0;
            for (int i = 0; i < 256; i++) if (dut.dmem[i] !== m_dmem[i]) bad++;
            check("rand_dmem", bad, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
